// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: memory geometry and FSM encodings.
package imem_loader_pkg;

    localparam int IMEM_DEPTH     = 1024;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; the first byte ends up in [31:23+1].
// Zero latency: word_full is high while three bytes are held, so the next accept completes the word.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            word <= '0;
            cnt  <= '0;
        end else if (accept) begin
            word <= {word[23:0], byte_in};
            cnt  <= cnt + 2'd1;
        end
    end

    assign word_full = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory one packed word at a time, stalling the CPU meanwhile.
// Latency: last byte of a word accepted at edge N -> mem_we in cycle N+1; done follows the final write.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_stall
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]          state;
    logic [ADDR_WIDTH:0] word_idx;
    logic [ADDR_WIDTH:0] count;
    logic [31:0]         packed_word;
    logic                word_full;
    logic                accept;

    assign accept = byte_valid & byte_ready;

    // The packer is cleared at the edge that ends WRITE, so its word stays intact while being written.
    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (mem_we),
        .accept    (accept),
        .byte_in   (byte_in),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            word_idx <= '0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        word_idx <= '0;
                        count    <= (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
                        state    <= (num_words == '0) ? S_DONE : S_RECV;
                    end
                end
                S_RECV: begin
                    if (accept && word_full) begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    state    <= ((word_idx + 1'b1) == count) ? S_DONE : S_RECV;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address and data are forced to zero outside WRITE so the port is quiet between words.
    assign byte_ready = (state == S_RECV);
    assign mem_we     = (state == S_WRITE);
    assign mem_addr   = mem_we ? {{(32 - ADDR_WIDTH - 3){1'b0}}, word_idx, 2'b00} : 32'd0;
    assign mem_wdata  = mem_we ? DATA_WIDTH'(packed_word) : '0;
    assign busy       = (state == S_RECV) || (state == S_WRITE);
    assign done       = (state == S_DONE);
    assign cpu_stall  = busy;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural imem capturing the write port.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] num_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        cpu_stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [0:1023];
    logic [31:0] wa [$];
    logic [31:0] wd [$];
    int          done_cnt;
    bit          busy_seen;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .cpu_stall  (cpu_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural imem plus continuous protocol checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("stall_eq_busy", {31'd0, cpu_stall}, {31'd0, busy});
            if (mem_we === 1'b1) begin
                check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
                check("addr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
                imem[mem_addr[11:2]] = mem_wdata;
            end
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!acc && n < 40) begin
            acc = byte_ready;
            tick();
            n++;
        end
        check("byte_accepted", {31'd0, acc}, 32'd1);
        byte_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic begin_load(input logic [10:0] n);
        wa.delete();
        wd.delete();
        done_cnt = 0;
        busy_seen = 1'b0;
        num_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic send_stream(input bit gap);
        logic [7:0] s [0:7];
        s = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        for (int i = 0; i < 8; i++) send(s[i], gap);
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwr"}, wa.size(), 2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, wa[0], 32'h0);
            check({tag, "_d0"}, wd[0], 32'h2008_0005);
            check({tag, "_a1"}, wa[1], 32'h4);
            check({tag, "_d1"}, wd[1], 32'h8C09_0004);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic big_load(input logic [10:0] n, input string tag);
        bit ok;
        logic [7:0] b;
        begin_load(n);
        for (int i = 0; i < 4096; i++) begin
            b = 8'(i);
            send(b, 1'b0);
        end
        wait_done();
        check({tag, "_nwr"}, wa.size(), 1024);
        ok = 1'b1;
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 32'(i * 4)) ok = 1'b0;
        check({tag, "_seq_addr"}, {31'd0, ok}, 32'd1);
        if (wa.size() == 1024) check({tag, "_last_addr"}, wa[1023], 32'h0000_0FFC);
        check({tag, "_w0"}, imem[0], 32'h0001_0203);
        check({tag, "_w517"}, imem[517], 32'h1415_1617);
        check({tag, "_w1023"}, imem[1023], 32'hFCFD_FEFF);
        check({tag, "_done_cnt"}, done_cnt, 1);
        repeat (3) tick();
        check({tag, "_no_extra_wr"}, wa.size(), 1024);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_words = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        repeat (2) tick();
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        // 1: two words back to back, exact latency
        begin_load(11'd2);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready", {31'd0, byte_ready}, 32'd1);
        send_stream(1'b0);
        check("t1_we", {31'd0, mem_we}, 32'd1);
        check("t1_addr", mem_addr, 32'h4);
        check("t1_wdata", mem_wdata, 32'h8C09_0004);
        tick();
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        tick();
        check("t1_done_low", {31'd0, done}, 32'd0);
        check_two_words("t1");
        check("t1_rd0", imem[0], 32'h2008_0005);
        check("t1_rd1", imem[1], 32'h8C09_0004);

        // 2: valid on every other cycle
        imem[0] = '0;
        imem[1] = '0;
        begin_load(11'd2);
        send_stream(1'b1);
        wait_done();
        check_two_words("t2");
        check("t2_rd1", imem[1], 32'h8C09_0004);

        // 3: zero-length load
        begin_load(11'd0);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t3_done_low", {31'd0, done}, 32'd0);
        check("t3_nwr", wa.size(), 0);
        check("t3_busy_seen", {31'd0, busy_seen}, 32'd0);

        // 4: reset mid-load, partial word discarded
        begin_load(11'd2);
        send(8'h20, 1'b0); send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        reset = 1'b1;
        #1;
        check("t4_ready", {31'd0, byte_ready}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_stall", {31'd0, cpu_stall}, 32'd0);
        check("t4_we", {31'd0, mem_we}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_addr", mem_addr, 32'd0);
        check("t4_nwr", wa.size(), 1);
        tick();
        reset = 1'b0;
        tick();
        begin_load(11'd1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        check("t4_w0_held", imem[0], 32'h2008_0005);
        send(8'h44, 1'b0);
        check("t4_re_addr", mem_addr, 32'h0);
        wait_done();
        check("t4_re_nwr", wa.size(), 1);
        check("t4_w0_new", imem[0], 32'h1122_3344);

        // 5: full depth, then an oversize count that must clamp
        big_load(11'd1024, "t5");
        big_load(11'd2047, "t5c");

        // 6: start and num_words poked mid-load are ignored
        begin_load(11'd3);
        send(8'h01, 1'b0); send(8'h02, 1'b0);
        start = 1'b1;
        num_words = 11'd1;
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1'b0);
        wait_done();
        check("t6_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            check("t6_a2", wa[2], 32'h8);
            check("t6_d0", wd[0], 32'h0102_0304);
            check("t6_d2", wd[2], 32'h1415_1617);
        end
        check("t6_done_cnt", done_cnt, 1);
        check("t6_idle_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
